// File: rtl/buf_pkg.sv
// Shared constants and helpers for the lifo_fifo_buffer slice: mode encoding,
// pointer/count width sizing and a wrap-increment for non-power-of-two depths.
package buf_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int buf_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/buf_ram.sv
// DATA_WIDTH x DEPTH storage: synchronous write, asynchronous read, no reset.
module buf_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Circular buffer usable as a stack or a queue, mode latched while empty.
// Optional almost_full/almost_empty outputs with LIFO_FIFO_ALMOST_FLAGS_EN.
module lifo_fifo_buffer
    import buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BUFFER_NO     = 8,
    parameter int ALMOST_MARGIN = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mode,
    input  logic                                 wen,
    input  logic                                 ren,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 clear_err,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 rvalid,
    output logic                                 full,
    output logic                                 empty,
    output logic [buf_width(BUFFER_NO+1)-1:0]    count,
    output logic                                 active_mode,
`ifdef LIFO_FIFO_ALMOST_FLAGS_EN
    output logic                                 almost_full,
    output logic                                 almost_empty,
`endif
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int PTR_W = buf_width(BUFFER_NO);
    localparam int CNT_W = buf_width(BUFFER_NO + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(BUFFER_NO);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_w;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  mode_q, mode_d;

    logic                  empty_w, full_w, ren_ok, wen_ok, lifo_w;
    logic [SUM_W-1:0]      sum_w;
    logic [PTR_W-1:0]      tail_w, top_w, raddr_w, waddr_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(BUFFER_NO));
    assign ren_ok  = ren & ~empty_w;
    assign wen_ok  = wen & (~full_w | ren_ok);
    assign lifo_w  = (mode_q == MODE_LIFO);

    // tail = (head + count) mod N; stack top sits one slot below the tail.
    assign sum_w   = SUM_W'(head_q) + SUM_W'(count_q);
    assign tail_w  = PTR_W'((sum_w >= DEPTH_S) ? (sum_w - DEPTH_S) : sum_w);
    assign top_w   = (tail_w == '0) ? PTR_W'(BUFFER_NO - 1) : (tail_w - PTR_W'(1));
    assign raddr_w = lifo_w ? top_w : head_q;
    assign waddr_w = (lifo_w & ren_ok) ? top_w : tail_w;

    buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_NO),
        .AW         (PTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wen_ok),
        .waddr_i (waddr_w),
        .wdata_i (data_in),
        .raddr_i (raddr_w),
        .rdata_o (rdata_w)
    );

    always_comb begin
        head_d   = head_q;
        count_d  = count_q + CNT_W'(wen_ok) - CNT_W'(ren_ok);
        data_d   = ren_ok ? rdata_w : data_q;
        rvalid_d = ren_ok;
        mode_d   = empty_w ? mode : mode_q;
        // A set on the same edge as clear_err wins.
        ovf_d    = (wen & ~wen_ok) | (ovf_q & ~clear_err);
        unf_d    = (ren & empty_w) | (unf_q & ~clear_err);
        if (!lifo_w && ren_ok) head_d = PTR_W'(wrap_inc(32'(head_q), BUFFER_NO));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            mode_q   <= MODE_LIFO;
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            mode_q   <= mode_d;
        end
    end

    assign data_out    = data_q;
    assign rvalid      = rvalid_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign active_mode = mode_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

`ifdef LIFO_FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (32'(count_q) >= BUFFER_NO - ALMOST_MARGIN);
    assign almost_empty = (32'(count_q) <= ALMOST_MARGIN);
`endif

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Directed bench for lifo_fifo_buffer: depth 8 instance plus a depth 5 instance
// sharing the same stimulus, the latter checked only in its own wrap section.
module tb_lifo_fifo_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0, wen = 1'b0, ren = 1'b0, clear_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout, dout5;
    logic       rvalid, full, empty, amode, ovf, unf;
    logic       rvalid5, full5, empty5, amode5, ovf5, unf5;
    logic [3:0] cnt;
    logic [2:0] cnt5;
`ifdef LIFO_FIFO_ALMOST_FLAGS_EN
    logic       af, ae, af5, ae5;
`endif

    int n_chk = 0;
    int n_fail = 0;

    lifo_fifo_buffer #(.DATA_WIDTH(8), .BUFFER_NO(8), .ALMOST_MARGIN(1)) dut (
        .clk(clk), .reset(reset), .mode(mode), .wen(wen), .ren(ren),
        .data_in(data_in), .clear_err(clear_err), .data_out(dout),
        .rvalid(rvalid), .full(full), .empty(empty), .count(cnt),
        .active_mode(amode),
`ifdef LIFO_FIFO_ALMOST_FLAGS_EN
        .almost_full(af), .almost_empty(ae),
`endif
        .overflow(ovf), .underflow(unf)
    );

    lifo_fifo_buffer #(.DATA_WIDTH(8), .BUFFER_NO(5), .ALMOST_MARGIN(1)) dut5 (
        .clk(clk), .reset(reset), .mode(mode), .wen(wen), .ren(ren),
        .data_in(data_in), .clear_err(clear_err), .data_out(dout5),
        .rvalid(rvalid5), .full(full5), .empty(empty5), .count(cnt5),
        .active_mode(amode5),
`ifdef LIFO_FIFO_ALMOST_FLAGS_EN
        .almost_full(af5), .almost_empty(ae5),
`endif
        .overflow(ovf5), .underflow(unf5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic [7:0] d);
        wen = w; ren = r; data_in = d;
        step();
        wen = 1'b0; ren = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_amode", 32'(amode), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;

        // 1. LIFO fill and drain
        for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 8'(i * 17));
        chk("lifo_full", 32'(full), 32'd1);
        chk("lifo_cnt8", 32'(cnt), 32'd8);
        op(1'b1, 1'b0, 8'h99);
        chk("lifo_ovf", 32'(ovf), 32'd1);
        chk("lifo_ovf_cnt", 32'(cnt), 32'd8);
        for (int i = 8; i >= 1; i--) begin
            op(1'b0, 1'b1, 8'h00);
            chk("lifo_pop", 32'(dout), 32'(i * 17));
            chk("lifo_rvalid", 32'(rvalid), 32'd1);
        end
        chk("lifo_empty", 32'(empty), 32'd1);
        step();
        chk("rvalid_drop", 32'(rvalid), 32'd0);
        chk("dout_hold", 32'(dout), 32'h11);
        clear_err = 1'b1; step(); clear_err = 1'b0;
        chk("ovf_clear", 32'(ovf), 32'd0);

        // 2. FIFO order and wrap
        mode = 1'b1;
        step();
        chk("fifo_amode", 32'(amode), 32'd1);
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("fifo_a", 32'(dout), 32'(8'hA0 + i));
        end
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'(8'hB0 + i));
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("fifo_b", 32'(dout), 32'(8'hB0 + i));
        end

        // 3b. FIFO full simultaneous read/write (head=3, tail wraps)
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("fifo_full", 32'(full), 32'd1);
        op(1'b1, 1'b1, 8'hD0);
        chk("fifo_rw_dout", 32'(dout), 32'hC0);
        chk("fifo_rw_cnt", 32'(cnt), 32'd8);
        chk("fifo_rw_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < 8; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("fifo_c", 32'(dout), 32'(8'hC0 + i));
        end
        op(1'b0, 1'b1, 8'h00);
        chk("fifo_d0", 32'(dout), 32'hD0);
        chk("fifo_empty", 32'(empty), 32'd1);

        // 3a. LIFO simultaneous read/write
        mode = 1'b0;
        step();
        chk("lifo_amode", 32'(amode), 32'd0);
        op(1'b1, 1'b0, 8'h11);
        op(1'b1, 1'b0, 8'h22);
        op(1'b1, 1'b0, 8'h33);
        op(1'b1, 1'b1, 8'h44);
        chk("lifo_rw_dout", 32'(dout), 32'h33);
        chk("lifo_rw_cnt", 32'(cnt), 32'd3);
        op(1'b0, 1'b1, 8'h00);
        chk("lifo_rw_top", 32'(dout), 32'h44);
        op(1'b0, 1'b1, 8'h00);
        chk("lifo_rw_22", 32'(dout), 32'h22);
        op(1'b0, 1'b1, 8'h00);
        chk("lifo_rw_11", 32'(dout), 32'h11);

        // 4. Underflow
        op(1'b0, 1'b1, 8'h00);
        chk("unf_set", 32'(unf), 32'd1);
        chk("unf_rvalid", 32'(rvalid), 32'd0);
        chk("unf_dout", 32'(dout), 32'h11);
        clear_err = 1'b1; step();
        chk("unf_clear", 32'(unf), 32'd0);
        ren = 1'b1; step(); ren = 1'b0; clear_err = 1'b0;
        chk("unf_set_wins", 32'(unf), 32'd1);
        clear_err = 1'b1; step(); clear_err = 1'b0;

        // 5. Mode lock
        op(1'b1, 1'b0, 8'h01);
        op(1'b1, 1'b0, 8'h02);
        mode = 1'b1;
        step();
        chk("lock_amode", 32'(amode), 32'd0);
        op(1'b0, 1'b1, 8'h00);
        chk("lock_02", 32'(dout), 32'h02);
        op(1'b0, 1'b1, 8'h00);
        chk("lock_01", 32'(dout), 32'h01);
        chk("lock_amode2", 32'(amode), 32'd0);
        step();
        chk("unlock_amode", 32'(amode), 32'd1);
        mode = 1'b0;
        step();

        // 6. Async reset mid-stream
        for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 8'(8'h60 + i));
        op(1'b0, 1'b1, 8'h00);
        chk("pre_rst_cnt", 32'(cnt), 32'd5);
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_rvalid", 32'(rvalid), 32'd0);
        #1 reset = 1'b1;
        op(1'b1, 1'b0, 8'h5A);
        op(1'b0, 1'b1, 8'h00);
        chk("post_rst", 32'(dout), 32'h5A);

        // 2c. FIFO wrap at depth 5
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        mode = 1'b1;
        step();
        chk("d5_amode", 32'(amode5), 32'd1);
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'hE0 + i));
        chk("d5_full", 32'(full5), 32'd1);
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("d5_first", 32'(dout5), 32'(8'hE0 + i));
        end
        for (int i = 5; i < 8; i++) op(1'b1, 1'b0, 8'(8'hE0 + i));
        chk("d5_cnt", 32'(cnt5), 32'd5);
        for (int i = 3; i < 8; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("d5_wrap", 32'(dout5), 32'(8'hE0 + i));
        end
        chk("d5_empty", 32'(empty5), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
Parametrised storage buffer that runs as a stack (LIFO) or a queue (FIFO), selected by a mode input. It is the successor to the plain lifo block and adds a runtime mode, occupancy count, registered read data with a valid strobe, simultaneous read/write and sticky error flags. It sits between producer and consumer logic wherever the team currently drops in lifo.

Parameters:
DATA_WIDTH, 8, entry width in bits
BUFFER_NO, 8, depth in entries; must be at least 2; need not be a power of two
ALMOST_MARGIN, 1, almost-flag threshold; used only with the optional feature

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
mode  in  1  requested mode: 0 = LIFO, 1 = FIFO
wen  in  1  write request
ren  in  1  read request
data_in  in  DATA_WIDTH  write data
clear_err  in  1  clears overflow and underflow
data_out  out  DATA_WIDTH  registered read data
rvalid  out  1  one-cycle strobe; data_out was updated by an accepted read
full  out  1  count == BUFFER_NO
empty  out  1  count == 0
count  out  clog2(BUFFER_NO+1)  occupancy
active_mode  out  1  mode currently in force
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (reset low, asynchronous, takes effect with no clock edge): count=0, head=0, data_out=0, rvalid=0, overflow=0, underflow=0, active_mode=0 (LIFO). Storage contents are not reset. A reset during operation discards all data immediately.
- Storage is a circular array with internal pointer head (FIFO oldest entry) and count. All modulo arithmetic is mod BUFFER_NO, with explicit wrap; no power-of-two masking.
- Accept rules:
  - ren_ok = ren & !empty
  - wen_ok = wen & (!full | ren_ok)
- Write address:
  - LIFO with ren_ok: head+count-1 (replaces the popped top).
  - All other cases (LIFO without ren_ok, and FIFO): head+count.
- Read address: LIFO uses head+count-1 (top); FIFO uses head.
- On ren_ok, the array is read before the write on the same edge: data_out <= entry at the read address, rvalid=1 for one cycle. Latency is 1 cycle from ren to data_out. data_out holds its value when there is no accepted read.
- count <= count + wen_ok - ren_ok. In FIFO mode, head <= head+1 on ren_ok. In LIFO mode, head is never moved.
- Simultaneous wen & ren:
  - LIFO returns the old top, stores the new word in its place, count unchanged.
  - FIFO reads the head and writes the tail, count unchanged. This is legal when full: no overflow.
- On empty, a write is accepted and the read is rejected.
- Mode: active_mode <= mode on any edge where count==0 (registered empty). While count>0, mode changes are ignored. The pointer formula is mode-independent, so a write on the switching edge is safe.
- Errors:
  - overflow <= 1 when wen & !wen_ok.
  - underflow <= 1 when ren & empty.
  - clear_err clears both flags; a set on the same edge wins over clear.
- full, empty and count come from the registered count with no added latency.

Optional Feature:
Macro LIFO_FIFO_ALMOST_FLAGS_EN.
- Defined: adds output ports almost_full (count >= BUFFER_NO-ALMOST_MARGIN) and almost_empty (count <= ALMOST_MARGIN), both combinational from count. Reset values: almost_full=0, almost_empty=1.
- Undefined: both ports and their logic are absent, and ALMOST_MARGIN is unused.

Decomposition:
- Shared package buf_pkg holds:
  - mode constants MODE_LIFO=1'b0, MODE_FIFO=1'b1
  - clog2-based width helper for pointer and count widths
  - a wrap-increment helper for non-power-of-two depth
- One sub-module, buf_ram: DATA_WIDTH x BUFFER_NO array, synchronous write and asynchronous read, no reset.
- Pointer, count, flag and mode logic live in lifo_fifo_buffer.

Test Plan:
1. LIFO fill and drain:
   - Write 0x11..0x88 -> full=1, count=8.
   - Write 0x99 -> overflow=1, count stays 8.
   - 8 reads -> data_out 0x88,0x77,...,0x11, each with rvalid one cycle after ren; empty=1 at the end.
2. FIFO order and wrap:
   - Set mode=1 while empty, write 0xA0..0xA7, read 8 -> 0xA0..0xA7 in order.
   - Write 0xB0..0xB2, read 3 -> 0xB0..0xB2 with head wrapped past 7.
   - Repeat with BUFFER_NO=5.
3. Simultaneous access:
   - LIFO, stack 0x11,0x22,0x33, wen=ren=1 with 0x44 -> data_out=0x33, count=3; next read -> 0x44.
   - FIFO full, wen=ren=1 -> count=8, overflow=0, oldest word returned.
4. Underflow:
   - ren on empty -> underflow=1, rvalid=0, data_out unchanged.
   - clear_err=1 -> underflow=0.
   - clear_err and ren on empty in the same cycle -> underflow stays 1.
5. Mode lock:
   - LIFO holding 0x01,0x02, drive mode=1 -> active_mode stays 0, reads return 0x02 then 0x01.
   - On the edge after empty -> active_mode=1.
6. Async reset mid-stream:
   - count=5, drop reset between clock edges -> count=0, empty=1, rvalid=0 immediately.
   - After release, write then read 0x5A -> 0x5A.
